// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU core.
// Opcode values, the FSM state encoding and the bit positions of the
// N/Z/C/V flags inside the 4-bit flags word.
package alu_seq_pkg;

  // Opcodes (4-bit, sampled with start)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_INV  = 4'd11;
  localparam logic [3:0] OP_NEG  = 4'd12;
  localparam logic [3:0] OP_STO  = 4'd13;
  localparam logic [3:0] OP_SWP  = 4'd14;
  localparam logic [3:0] OP_LOAD = 4'd15;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit positions inside flags = {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational ALU slice for every single-cycle arithmetic/logic opcode
// (ADD, SUB, CMP, the bitwise group, INV, NEG).
// Ports:
//   a, b  : operands
//   op    : opcode; shifts and register-move opcodes yield zero here
//   y     : result
//   flags : {N,Z,C,V} for that result
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           c;
  logic           v;

  // Extra top bit captures carry (add) or borrow (subtract).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum[WIDTH-1:0];
        c = sum[WIDTH];
        // Overflow: like-signed operands producing an opposite-signed result.
        v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y = diff[WIDTH-1:0];
        c = ~diff[WIDTH];  // carry means "no borrow", i.e. a >= b
        v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: begin
        y[2] = (a > b);
        y[1] = (a == b);
        y[0] = (a < b);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_INV:  y = ~a;
      OP_NEG: begin
        y = '0 - a;
        v = (a == MIN_NEG);  // the most negative value has no positive twin
      end
      default: y = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = y[WIDTH-1];
    flags[FLAG_Z] = ~|y;
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: operand registers A/B, result register y, flags and
// a busy/done handshake. Single-cycle opcodes complete at the start edge;
// SHL/SHR run one bit per clock through a serial shifter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : synchronous clear of all state, aborts an operation
//   din            : operand input
//   load_a, load_b : load din into A / B (idle only, start takes priority)
//   start, op      : execute opcode op (ignored while busy)
//   a_q, b_q, y    : operand and result registers
//   flags          : {N,Z,C,V} of the last completed operation
//   busy           : a serial shift is in flight
//   done           : one-cycle pulse when y/flags update
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit WRITEBACK = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             start,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int S = $clog2(WIDTH);

  state_t           state, state_d;
  logic [WIDTH-1:0] a_d, b_d, y_d;
  logic [3:0]       flags_d;
  logic             done_d;
  logic [WIDTH-1:0] work, work_d;   // value being shifted
  logic [S-1:0]     cnt, cnt_d;     // remaining shift steps
  logic             cbit, cbit_d;   // last bit shifted out
  logic             dir_r, dir_d;   // 1 = shift right

  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_flags;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a     (a_q),
    .b     (b_q),
    .op    (op),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // N/Z from a value with C and V cleared (register-move opcodes).
  function automatic logic [3:0] nz_flags(input logic [WIDTH-1:0] v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = v[WIDTH-1];
    f[FLAG_Z] = ~|v;
    return f;
  endfunction

  assign busy = (state == ST_SHIFT);

  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y;
    flags_d = flags;
    done_d  = 1'b0;
    work_d  = work;
    cnt_d   = cnt;
    cbit_d  = cbit;
    dir_d   = dir_r;

    if (clr) begin
      state_d = ST_IDLE;
      a_d     = '0;
      b_d     = '0;
      y_d     = '0;
      flags_d = '0;
      work_d  = '0;
      cnt_d   = '0;
      cbit_d  = 1'b0;
      dir_d   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Start wins over any simultaneous load.
            case (op)
              OP_SHL, OP_SHR: begin
                state_d = ST_SHIFT;
                work_d  = a_q;
                cnt_d   = b_q[S-1:0];
                cbit_d  = 1'b0;
                dir_d   = (op == OP_SHR);
              end
              OP_STO: begin
                a_d     = y;
                flags_d = nz_flags(y);
                done_d  = 1'b1;
              end
              OP_SWP: begin
                a_d     = b_q;
                b_d     = a_q;
                y_d     = a_q;
                flags_d = nz_flags(a_q);
                done_d  = 1'b1;
              end
              OP_LOAD: begin
                a_d     = din;
                b_d     = a_q;
                y_d     = din;
                flags_d = nz_flags(din);
                done_d  = 1'b1;
              end
              default: begin
                y_d     = alu_y;
                flags_d = alu_flags;
                done_d  = 1'b1;
                if (WRITEBACK) a_d = alu_y;
              end
            endcase
          end else begin
            if (load_a) a_d = din;
            if (load_b) b_d = din;
          end
        end

        ST_SHIFT: begin
          if (cnt == '0) begin
            state_d               = ST_IDLE;
            y_d                   = work;
            flags_d               = '0;
            flags_d[FLAG_N]       = work[WIDTH-1];
            flags_d[FLAG_Z]       = ~|work;
            flags_d[FLAG_C]       = cbit;
            done_d                = 1'b1;
            if (WRITEBACK) a_d    = work;
          end else begin
            if (dir_r) begin
              cbit_d = work[0];
              work_d = work >> 1;
            end else begin
              cbit_d = work[WIDTH-1];
              work_d = work << 1;
            end
            cnt_d = cnt - 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  // All registers here are small flops, so every one is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      y     <= '0;
      flags <= '0;
      done  <= 1'b0;
      work  <= '0;
      cnt   <= '0;
      cbit  <= 1'b0;
      dir_r <= 1'b0;
    end else begin
      state <= state_d;
      a_q   <= a_d;
      b_q   <= b_d;
      y     <= y_d;
      flags <= flags_d;
      done  <= done_d;
      work  <= work_d;
      cnt   <= cnt_d;
      cbit  <= cbit_d;
      dir_r <= dir_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8, WRITEBACK=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_seq_core;

  localparam int W    = 8;
  localparam int M    = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);
  localparam bit WB   = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_a = 1'b0;
  logic         load_b = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a_q, b_q, y;
  logic [3:0]   flags;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  // Reference state
  int m_a = 0, m_b = 0, m_y = 0, m_f = 0;

  alu_seq_core #(.WIDTH(W), .WRITEBACK(WB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .din    (din),
    .load_a (load_a),
    .load_b (load_b),
    .start  (start),
    .op     (op),
    .a_q    (a_q),
    .b_q    (b_q),
    .y      (y),
    .flags  (flags),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= HALF) ? v - (1 << W) : v;
  endfunction

  // Architectural result of one opcode from the current model state.
  task automatic model_exec(input int opc, input int dv,
                            output int ey, output int ef, output int ea,
                            output int eb, output int elat);
    int a, b, yy, c, v, sa, sb, d;
    a = m_a; b = m_b; yy = m_y; c = 0; v = 0;
    sa = to_signed(a); sb = to_signed(b);
    d = b % W;
    ea = a; eb = b; elat = 1;
    case (opc)
      0:  begin yy = (a + b) & M; c = int'((a + b) > M);
                v = int'((sa + sb > HALF - 1) || (sa + sb < -HALF)); end
      1:  begin yy = (a - b) & M; c = int'(a >= b);
                v = int'((sa - sb > HALF - 1) || (sa - sb < -HALF)); end
      2:  begin yy = (a << d) & M; c = (d == 0) ? 0 : (a >> (W - d)) & 1; elat = d + 2; end
      3:  begin yy = a >> d;       c = (d == 0) ? 0 : (a >> (d - 1)) & 1; elat = d + 2; end
      4:  yy = 4 * int'(a > b) + 2 * int'(a == b) + int'(a < b);
      5:  yy = a & b;
      6:  yy = a | b;
      7:  yy = a ^ b;
      8:  yy = ~(a & b) & M;
      9:  yy = ~(a | b) & M;
      10: yy = ~(a ^ b) & M;
      11: yy = ~a & M;
      12: begin yy = (-a) & M; v = int'(a == HALF); end
      13: ea = yy;
      14: begin ea = b; eb = a; yy = a; end
      default: begin ea = dv; eb = a; yy = dv; end
    endcase
    if (WB && opc <= 12) ea = yy;
    ey = yy;
    ef = 8 * int'(yy >= HALF) + 4 * int'(yy == 0) + 2 * c + v;
  endtask

  task automatic load_ab(input int av, input int bv);
    @(negedge clk);
    din = av[W-1:0]; load_a = 1'b1;
    @(negedge clk);
    din = bv[W-1:0]; load_a = 1'b0; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    m_a = av; m_b = bv;
  endtask

  task automatic load_both(input int v);
    @(negedge clk);
    din = v[W-1:0]; load_a = 1'b1; load_b = 1'b1;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;
    m_a = v; m_b = v;
  endtask

  // Issue one opcode, wait (bounded) for done, compare everything.
  // While busy, loads are hammered with random data; they must be ignored.
  task automatic run_op(input int opc, input int dv, input bit la);
    int ey, ef, ea, eb, elat, lat;
    model_exec(opc, dv, ey, ef, ea, eb, elat);
    @(negedge clk);
    op = opc[3:0]; din = dv[W-1:0]; start = 1'b1; load_a = la;
    @(negedge clk);
    start = 1'b0; load_a = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      check($sformatf("busy op%0d", opc), busy, 1);
      load_a = 1'b1; load_b = 1'b1; din = W'($urandom);
      @(negedge clk);
      lat++;
    end
    load_a = 1'b0; load_b = 1'b0; din = dv[W-1:0];
    check($sformatf("latency op%0d", opc), lat, elat);
    check($sformatf("y op%0d", opc), y, ey);
    check($sformatf("flags op%0d", opc), flags, ef);
    check($sformatf("a op%0d", opc), a_q, ea);
    check($sformatf("b op%0d", opc), b_q, eb);
    check($sformatf("busy_at_done op%0d", opc), busy, 0);
    m_a = ea; m_b = eb; m_y = ey; m_f = ef;
    @(negedge clk);
    check($sformatf("done_pulse op%0d", opc), done, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " a"}, a_q, 0);
    check({tag, " b"}, b_q, 0);
    check({tag, " y"}, y, 0);
    check({tag, " flags"}, flags, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  task automatic watch_no_done(input string tag);
    int n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    int ndone, first, ey, ef, ea, eb, elat;

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // ADD with signed overflow
    load_ab(8'h7F, 8'h01);
    run_op(0, 0, 1'b0);
    check("add y literal", y, 8'h80);
    check("add flags literal", flags, 4'b1001);

    // SUB to zero then CMP equal
    load_ab(8'h05, 8'h05);
    run_op(1, 0, 1'b0);
    check("sub flags literal", flags, 4'b0110);
    run_op(4, 0, 1'b0);
    check("cmp y literal", y, 8'h02);

    // Serial shifts, including distance 0
    load_ab(8'h81, 8'h03);
    run_op(2, 0, 1'b0);
    check("shl3 y literal", y, 8'h08);
    load_ab(8'h81, 8'h01);
    run_op(2, 0, 1'b0);
    check("shl1 y literal", y, 8'h02);
    check("shl1 c", flags[1], 1);
    load_ab(8'h3C, 8'h00);
    run_op(3, 0, 1'b0);
    check("shr0 y literal", y, 8'h3C);
    load_ab(8'hC5, 8'h05);
    run_op(3, 0, 1'b0);

    // start re-pulsed mid-shift must be ignored: exactly one done
    load_ab(8'h5A, 8'h07);
    model_exec(2, 0, ey, ef, ea, eb, elat);
    @(negedge clk);
    op = 4'd2; start = 1'b1;
    ndone = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin op = 4'd0; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    check("repulse done count", ndone, 1);
    check("repulse latency", first, elat);
    check("repulse y", y, ey);
    check("repulse flags", flags, ef);
    m_a = ea; m_b = eb; m_y = ey; m_f = ef;

    // SWP, STO, then start with a simultaneous load_a
    load_ab(8'h12, 8'h34);
    run_op(14, 0, 1'b0);
    check("swp a literal", a_q, 8'h34);
    check("swp b literal", b_q, 8'h12);
    run_op(13, 0, 1'b0);
    check("sto a literal", a_q, 8'h12);
    run_op(5, 8'hAA, 1'b1);
    check("start_beats_load a", a_q, 8'h12);
    run_op(15, 8'h9C, 1'b0);
    run_op(12, 0, 1'b0);
    load_ab(8'h80, 8'h00);
    run_op(12, 0, 1'b0);

    // Randomised operations
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) load_ab(int'($urandom_range(0, M)), int'($urandom_range(0, M)));
      else if (r == 3) load_both(int'($urandom_range(0, M)));
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, M)), 1'($urandom));
    end

    // Async reset in the third busy cycle of a long shift
    load_ab(8'hA5, 8'h07);
    @(negedge clk);
    op = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort busy before rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("rst abort");
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("rst abort no done");
    m_a = 0; m_b = 0; m_y = 0; m_f = 0;

    // Synchronous clear in the third busy cycle
    load_ab(8'hA5, 8'h07);
    @(negedge clk);
    op = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clr busy before", busy, 1);
    clr = 1'b1;
    #1;
    check("clr waits for edge", a_q, 8'hA5);
    @(negedge clk);
    check_zero("clr abort");
    clr = 1'b0;
    watch_no_done("clr abort no done");
    m_a = 0; m_b = 0; m_y = 0; m_f = 0;

    // Normal operation resumes after clear
    load_ab(8'h10, 8'h22);
    run_op(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised successor of the 8-bit board-level ALU.
- Holds operand registers A and B and a result register Y, and executes one 4-bit opcode per start pulse.
- Single-cycle operations finish in one cycle; variable-distance shifts run serially through a small FSM.
- Reports N/Z/C/V flags and a busy/done handshake to the board-level wrapper (switches, buttons, LEDs, 7-segment).

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- WRITEBACK, 0, if 1 every ALU result (ops 0-12) is also written into A (accumulator mode).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of A, B, Y and flags; aborts any operation.
- din  input  WIDTH  operand input (switches).
- load_a  input  1  in IDLE: A <= din.
- load_b  input  1  in IDLE: B <= din.
- start  input  1  single-cycle pulse, execute op.
- op  input  4  opcode, sampled with start.
- a_q  output  WIDTH  current A.
- b_q  output  WIDTH  current B.
- y  output  WIDTH  result register.
- flags  output  4  {N,Z,C,V} of last completed op.
- busy  output  1  high while an op is in flight.
- done  output  1  one-cycle pulse when y/flags update.

Behaviour:
- Reset (rst_n low, async): A, B, y, flags, done, busy all 0; FSM in IDLE.
- clr (sync) has the same effect as reset at the next edge, in any state; it overrides start/load.
- Opcodes, all unsigned unless noted:
  - 0 ADD: Y=A+B; C=carry out; V=signed overflow.
  - 1 SUB: Y=A-B; C=no-borrow (A>=B); V=signed overflow.
  - 2 SHL: A<<B[S-1:0], with S=$clog2(WIDTH).
  - 3 SHR: logical, same distance rule as SHL.
  - 4 CMP: Y={0..,A>B,A==B,A<B}.
  - 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, 10 XNOR (bitwise A op B).
  - 11 INV: Y=~A.
  - 12 NEG: Y=-A; V=1 iff A==100..0.
  - 13 STO: A<=Y; Y unchanged.
  - 14 SWP: A<=B, B<=A; Y=old A.
  - 15 LOAD: A<=din, B<=old A; Y=din.
- Flags:
  - N=Y[WIDTH-1]; Z=(Y==0), evaluated on the new Y.
  - C and V are 0 except where defined above and for shifts.
  - Shift C = last bit shifted out; 0 for distance 0.
  - Ops 13-15 update N/Z from the new Y and clear C/V.
- FSM states:
  - IDLE: busy=0. start -> single-cycle op: y/flags/A/B written at the sampling edge, done=1 the next cycle, stay IDLE. start with op 2/3 -> SHIFT, work<=A, cnt<=distance, busy=1.
  - SHIFT: at each edge, if cnt==0 then y<=work, flags updated, done<=1, go to IDLE; else shift work by 1, record bit out, cnt<=cnt-1.
  - Shift latency: done high distance+2 cycles after the start edge; busy high throughout, low in the done cycle.
- start while busy: ignored; op is not queued.
- load_a/load_b while busy: ignored.
- load and start in the same IDLE cycle: start wins, loads dropped.
- load_a and load_b together: both load din.
- WRITEBACK=1: ops 0-12 also write A<=new Y in the same cycle y is written.
- done never asserts without a preceding accepted start.
- clr or rst_n during SHIFT: abort; no done pulse.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_ADD..OP_LOAD), FSM state encoding (ST_IDLE, ST_SHIFT), flag bit indices.
- One combinational sub-module, alu_seq_comb: produces Y and flags for ops 0,1,4-12 from A, B, op.
- The FSM, registers and serial shifter stay in alu_seq_core.

Test Plan:
- WIDTH=8, load A=0x7F, B=0x01, ADD -> done 1 cycle later; y=0x80, flags N=1 Z=0 C=0 V=1.
- A=0x05, B=0x05, SUB then CMP -> first y=0x00, Z=1, C=1; then y=0x02.
- A=0x81, B=0x03, SHL -> busy for 4 cycles, done on cycle 5 after start; y=0x08, C=0. Repeat with B=0x01: y=0x02, C=1.
- A=0x3C, B=0x00, SHR -> done 2 cycles after start; y=0x3C, C=0. start re-pulsed mid-shift on a B=7 run: ignored, single done.
- A=0x12, B=0x34, SWP then STO -> after SWP A=0x34, B=0x12, y=0x12; after STO A=0x12. load_a with start in the same cycle: A not overwritten by din.
- Start SHL with B=7, assert rst_n low on the 3rd busy cycle -> all outputs 0 immediately; no done after release. Repeat with clr: same result one edge later.
